// File: rtl/dpram_rr_arbiter.sv
// Round-robin arbiter that shares both ports of a 64x8 dual-port RAM among NREQ requesters.
// Optional DPRAM_ARB_CONFLICT_CNT_EN adds a saturating address-conflict cycle counter.
module dpram_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 6,
  parameter int DW   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rvalid,
  output logic [NREQ*DW-1:0] rdata,
  output logic [AW-1:0]     ram_addr_a,
  output logic [AW-1:0]     ram_addr_b,
  output logic [DW-1:0]     ram_data_a,
  output logic [DW-1:0]     ram_data_b,
  output logic              ram_we_a,
  output logic              ram_we_b,
  input  logic [DW-1:0]     ram_q_a,
  input  logic [DW-1:0]     ram_q_b
`ifdef DPRAM_ARB_CONFLICT_CNT_EN
  ,
  output logic [15:0]       conflict_cnt
`endif
);

  localparam int PW = $clog2(NREQ);
  typedef logic [PW-1:0] idx_t;

  function automatic idx_t wrap(input int v);
    return idx_t'(v % NREQ);
  endfunction

  idx_t ptr_q, ptr_d;
  idx_t own_a_q, own_a_d;
  idx_t own_b_q, own_b_d;
  logic val_a_q, val_a_d;
  logic val_b_q, val_b_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;
  logic [NREQ*DW-1:0] rdata_q, rdata_d;

  idx_t j_scan, idx_a, idx_b, last;
  logic found_a, found_b, skip;
  logic act_a, act_b;

  // Scan from ptr; B is the first later requester that does not clash with A
  always_comb begin
    j_scan  = '0;
    idx_a   = '0;
    idx_b   = '0;
    found_a = 1'b0;
    found_b = 1'b0;
    skip    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j_scan = wrap(int'(ptr_q) + k);
      if (req[j_scan]) begin
        if (!found_a) begin
          found_a = 1'b1;
          idx_a   = j_scan;
        end else if (!found_b) begin
          if (addr[j_scan*AW +: AW] == addr[idx_a*AW +: AW]
              && (we[j_scan] || we[idx_a])) begin
            skip = 1'b1;
          end else begin
            found_b = 1'b1;
            idx_b   = j_scan;
          end
        end
      end
    end
  end

  always_comb begin
    act_a = found_a & ~rst;
    act_b = found_b & ~rst;
    gnt   = '0;
    if (act_a) gnt[idx_a] = 1'b1;
    if (act_b) gnt[idx_b] = 1'b1;
    ram_addr_a = act_a ? addr[idx_a*AW +: AW]  : '0;
    ram_data_a = act_a ? wdata[idx_a*DW +: DW] : '0;
    ram_we_a   = act_a & we[idx_a];
    ram_addr_b = act_b ? addr[idx_b*AW +: AW]  : '0;
    ram_data_b = act_b ? wdata[idx_b*DW +: DW] : '0;
    ram_we_b   = act_b & we[idx_b];
  end

  always_comb begin
    last     = found_b ? idx_b : idx_a;
    ptr_d    = act_a ? wrap(int'(last) + 1) : ptr_q;
    own_a_d  = idx_a;
    own_b_d  = idx_b;
    val_a_d  = act_a & ~we[idx_a];
    val_b_d  = act_b & ~we[idx_b];
    rvalid_d = '0;
    rdata_d  = rdata_q;
    if (val_a_q) begin
      rvalid_d[own_a_q]             = 1'b1;
      rdata_d[own_a_q*DW +: DW]     = ram_q_a;
    end
    if (val_b_q) begin
      rvalid_d[own_b_q]             = 1'b1;
      rdata_d[own_b_q*DW +: DW]     = ram_q_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q    <= '0;
      own_a_q  <= '0;
      own_b_q  <= '0;
      val_a_q  <= 1'b0;
      val_b_q  <= 1'b0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      ptr_q    <= ptr_d;
      own_a_q  <= own_a_d;
      own_b_q  <= own_b_d;
      val_a_q  <= val_a_d;
      val_b_q  <= val_b_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

`ifdef DPRAM_ARB_CONFLICT_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (skip && act_a && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign conflict_cnt = cnt_q;
`else
  logic unused_skip;
  assign unused_skip = skip;
`endif

endmodule

// File: tb/tb_dpram_rr_arbiter.sv
// Directed bench for dpram_rr_arbiter with a behavioural 64x8 dual-port RAM.
module tb_dpram_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, we;
  logic [23:0] addr;
  logic [31:0] wdata;
  logic [3:0]  gnt, rvalid;
  logic [31:0] rdata;
  logic [5:0]  ram_addr_a, ram_addr_b;
  logic [7:0]  ram_data_a, ram_data_b;
  logic        ram_we_a, ram_we_b;
  logic [7:0]  ram_q_a, ram_q_b;
`ifdef DPRAM_ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  logic seen3;

  logic [7:0] mem [64];

  dpram_rr_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .gnt        (gnt),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .ram_addr_a (ram_addr_a),
    .ram_addr_b (ram_addr_b),
    .ram_data_a (ram_data_a),
    .ram_data_b (ram_data_b),
    .ram_we_a   (ram_we_a),
    .ram_we_b   (ram_we_b),
    .ram_q_a    (ram_q_a),
    .ram_q_b    (ram_q_b)
`ifdef DPRAM_ARB_CONFLICT_CNT_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
    if (ram_we_b) mem[ram_addr_b] <= ram_data_b;
    ram_q_a <= mem[ram_addr_a];
    ram_q_b <= mem[ram_addr_b];
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int i, input logic w, input logic [5:0] a,
                     input logic [7:0] d);
    req[i]          = 1'b1;
    we[i]           = w;
    addr[i*6 +: 6]  = a;
    wdata[i*8 +: 8] = d;
  endtask

  task automatic rst_pulse();
    req = '0;
    we  = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    repeat (2) tick();
    rst = 1'b0;

    // idle after reset
    for (int c = 0; c < 10; c++) begin
      #2;
      chk("idle_gnt", 64'(gnt), 64'(0));
      chk("idle_we", 64'({ram_we_a, ram_we_b}), 64'(0));
      chk("idle_rvalid", 64'(rvalid), 64'(0));
      tick();
    end

    // preload through requester 0 alone, granted every cycle
    put(0, 1'b1, 6'd0, 8'h11); #2;
    chk("pre0", 64'({gnt, ram_we_a, ram_addr_a, ram_data_a}), 64'({4'b0001, 1'b1, 6'd0, 8'h11}));
    tick();
    put(0, 1'b1, 6'd1, 8'h22); #2;
    chk("pre1", 64'({gnt, ram_we_a, ram_addr_a, ram_data_a}), 64'({4'b0001, 1'b1, 6'd1, 8'h22}));
    tick();
    put(0, 1'b1, 6'd2, 8'h33); #2;
    chk("pre2", 64'({gnt, ram_we_a, ram_addr_a, ram_data_a}), 64'({4'b0001, 1'b1, 6'd2, 8'h33}));
    tick();
    put(0, 1'b1, 6'd3, 8'h44); #2;
    chk("pre3", 64'({gnt, ram_we_a, ram_addr_a, ram_data_a}), 64'({4'b0001, 1'b1, 6'd3, 8'h44}));
    tick();
    put(0, 1'b1, 6'd20, 8'h3C); #2;
    chk("pre20", 64'({gnt, ram_we_a, ram_addr_a, ram_data_a}), 64'({4'b0001, 1'b1, 6'd20, 8'h3C}));
    tick();

    // write then read-after-write
    put(0, 1'b1, 6'd5, 8'hA5); #2;
    chk("raw_w", 64'({gnt, ram_we_a, ram_addr_a, ram_data_a}), 64'({4'b0001, 1'b1, 6'd5, 8'hA5}));
    tick();
    req[0] = 1'b0;
    put(1, 1'b0, 6'd5, 8'h00); #2;
    chk("raw_r", 64'({gnt, ram_we_a, ram_addr_a}), 64'({4'b0010, 1'b0, 6'd5}));
    tick();
    req[1] = 1'b0; #2;
    chk("raw_lat1", 64'(rvalid), 64'(0));
    tick(); #2;
    chk("raw_rvalid", 64'(rvalid), 64'(4'b0010));
    chk("raw_rdata", 64'(rdata[15:8]), 64'(8'hA5));
    tick(); #2;
    chk("raw_pulse", 64'(rvalid), 64'(0));

    // four readers, distinct addresses
    rst_pulse();
    for (int i = 0; i < 4; i++) put(i, 1'b0, 6'(i), 8'h00);
    #2;
    chk("rr_c1", 64'(gnt), 64'(4'b0011));
    tick(); #2;
    chk("rr_c2", 64'(gnt), 64'(4'b1100));
    tick(); #2;
    chk("rr_c3", 64'(gnt), 64'(4'b0011));
    chk("rr_rv3", 64'(rvalid), 64'(4'b0011));
    chk("rr_rd01", 64'(rdata[15:0]), 64'(16'h2211));
    tick();
    req = '0; #2;
    chk("rr_rv4", 64'(rvalid), 64'(4'b1100));
    chk("rr_rd23", 64'(rdata[31:16]), 64'(16'h4433));
    tick(); #2;
    chk("rr_rv5", 64'(rvalid), 64'(4'b0011));
    tick(); #2;
    chk("rr_rv6", 64'(rvalid), 64'(0));

    // write/read conflict on the same address
    rst_pulse();
    put(0, 1'b1, 6'd9, 8'h5A);
    put(1, 1'b0, 6'd9, 8'h00); #2;
    chk("cf_gnt1", 64'({gnt, ram_we_a, ram_we_b}), 64'({4'b0001, 1'b1, 1'b0}));
    tick();
    req[0] = 1'b0; #2;
    chk("cf_gnt2", 64'(gnt), 64'(4'b0010));
`ifdef DPRAM_ARB_CONFLICT_CNT_EN
    chk("cf_cnt", 64'(conflict_cnt), 64'(1));
`endif
    tick();
    req[1] = 1'b0;
    tick(); #2;
    chk("cf_rvalid", 64'(rvalid), 64'(4'b0010));
    chk("cf_rdata", 64'(rdata[15:8]), 64'(8'h5A));
`ifdef DPRAM_ARB_CONFLICT_CNT_EN
    chk("cf_cnt_hold", 64'(conflict_cnt), 64'(1));
`endif

    // two reads of the same address share the cycle
    rst_pulse();
    put(2, 1'b0, 6'd20, 8'h00);
    put(3, 1'b0, 6'd20, 8'h00); #2;
    chk("rr_same", 64'({gnt, ram_addr_a, ram_addr_b}), 64'({4'b1100, 6'd20, 6'd20}));
    tick();
    req = '0; #2;
    chk("rs_lat1", 64'(rvalid), 64'(0));
    tick(); #2;
    chk("rs_rvalid", 64'(rvalid), 64'(4'b1100));
    chk("rs_rdata", 64'(rdata[31:16]), 64'(16'h3C3C));
    tick();

    // starvation bound, starting with ptr=1
    rst_pulse();
    put(0, 1'b0, 6'd0, 8'h00); #2;
    chk("sv_pre", 64'(gnt), 64'(4'b0001));
    tick();
    for (int i = 0; i < 4; i++) put(i, 1'b0, 6'(i), 8'h00);
    seen3 = 1'b0;
    #2;
    chk("sv_g1", 64'(gnt), 64'(4'b0110));
    seen3 = seen3 | gnt[3];
    tick(); #2;
    chk("sv_g2", 64'(gnt), 64'(4'b1001));
    seen3 = seen3 | gnt[3];
    tick();
    chk("sv_bound", 64'(seen3), 64'(1));
    req = '0;
    repeat (3) tick();

    // async reset with one read returning and one in flight
    put(1, 1'b0, 6'd5, 8'h00); #2;
    chk("mr_g1", 64'(gnt), 64'(4'b0010));
    tick();
    req[1] = 1'b0;
    put(2, 1'b0, 6'd5, 8'h00); #2;
    chk("mr_g2", 64'(gnt), 64'(4'b0100));
    tick(); #2;
    chk("mr_rv", 64'(rvalid), 64'(4'b0010));
    chk("mr_rd", 64'(rdata[15:8]), 64'(8'hA5));
    rst = 1'b1; #1;
    chk("mr_async", 64'({gnt, rvalid, ram_we_a, ram_we_b}), 64'(0));
    chk("mr_rdata", 64'(rdata), 64'(0));
    tick();
    rst = 1'b0;
    req = '0;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk("mr_discard", 64'(rvalid), 64'(0));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dpram_rr_arbiter.md
Name: dpram_rr_arbiter

Overview:
- Round-robin arbiter that shares the two ports of the team's 64x8 dual-port RAM among NREQ requesters.
- Grants up to two accesses per cycle: the first winner drives RAM port A, the second drives port B.
- Prevents same-address conflicts whenever a write is involved.
- Returns read data to the owning requester one cycle after grant.
- Sits between requester blocks and the RAM; drives the RAM's addr/data/we pins and collects q_a/q_b.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AW, 6, address width; matches the 64-entry RAM.
- DW, 8, data width.

Ports:
- clk  in  1  clock; all registers on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  request per requester.
- we  in  NREQ  1=write, 0=read, per requester.
- addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW].
- wdata  in  NREQ*DW  packed write data.
- gnt  out  NREQ  combinational grant, one-hot-or-two-hot.
- rvalid  out  NREQ  registered; read data valid for requester i.
- rdata  out  NREQ*DW  registered packed read data.
- ram_addr_a, ram_addr_b  out  AW  RAM port addresses.
- ram_data_a, ram_data_b  out  DW  RAM write data.
- ram_we_a, ram_we_b  out  1  RAM write enables.
- ram_q_a, ram_q_b  in  DW  RAM read data; valid the cycle after a read is issued.

Behaviour:
- Reset (async, rst=1):
  - ptr=0, owner regs cleared, rvalid=0, rdata=0.
  - gnt=0 and ram_we_a/b=0 while rst is high.
  - ram_addr/ram_data outputs are 0 when the corresponding port is idle.
- Handshake:
  - Requester holds req, we, addr and wdata stable until it sees gnt[i]=1 in the same cycle.
  - The access is issued at that rising edge; the requester may drop req or present a new access next cycle.
- Selection (combinational, each cycle):
  - Scan indices ptr, ptr+1, ... mod NREQ.
  - First requester found = winner A, driven to port A.
  - Next requester found whose access does not conflict with A = winner B, driven to port B.
  - Conflict: addr equal AND (we_A or we_B). Two reads to the same address do not conflict and are both granted.
  - A conflicting requester is skipped this cycle and keeps req asserted; the scan continues for a B winner past it.
- Pointer:
  - On any grant, ptr <= (index of last winner + 1) mod NREQ.
  - With no grant, ptr holds.
  - Guarantees any requester waits at most ceil(NREQ/2) granted cycles.
- Read return:
  - On a read grant via port X, register owner_X = index and valid_X = 1.
  - Next cycle: rvalid[owner_X] = 1 and rdata slice = ram_q_X, both registered so they appear one cycle after that edge.
  - Read latency, gnt edge to rvalid: 2 edges, i.e. rvalid is high in cycle N+2 when gnt is high in cycle N.
  - rvalid is a single-cycle pulse per read; rdata holds its value until overwritten.
- Writes: produce no rvalid.
- Simultaneous read completions on both ports go to different requesters (one grant per requester per cycle); both rvalid bits assert together.
- Back-to-back:
  - A requester may be granted every cycle if it is the only requester.
  - Read-after-write to the same address in consecutive cycles returns the new data (RAM write occurs before the later read edge).
- Mid-operation reset: in-flight reads are discarded; no rvalid is produced for them after reset deasserts.

Optional Feature:
- Macro: DPRAM_ARB_CONFLICT_CNT_EN.
- When defined:
  - Adds output conflict_cnt [15:0].
  - Increments by 1 each cycle in which at least one requesting index was skipped due to an address conflict.
  - Saturates at 16'hFFFF; reset to 0.
- When undefined: the port and counter do not exist. Arbitration behaviour is identical either way.

Test Plan:
- Reset then idle, all req=0:
  - gnt=0, ram_we_a=ram_we_b=0, rvalid=0 for 10 cycles.
  - Assert rst mid-run: all outputs return to 0 asynchronously.
- Req0 write addr 5 data 8'hA5; next cycle req1 read addr 5:
  - ram_we_a=1 on the first grant.
  - rvalid[1]=1 with rdata[15:8]=8'hA5 two edges after gnt[1].
- Req0..3 all reading distinct addresses 0..3, held continuously, ptr=0:
  - Cycle 1 gnt=4'b0011, cycle 2 gnt=4'b1100, cycle 3 gnt=4'b0011.
  - Each requester gets rvalid with its address's data.
- Req0 write addr 9 and req1 read addr 9 in the same cycle:
  - gnt=4'b0001 only; gnt[1] follows next cycle.
  - rvalid[1] returns the newly written value.
  - conflict_cnt=1 when the macro is defined.
- Req2 and req3 both read addr 20 (value 8'h3C) in the same cycle:
  - gnt=4'b1100.
  - Both rvalid[2] and rvalid[3] rise together with data 8'h3C.
- Requester 3 continuously requesting while 0..2 saturate:
  - gnt[3] is asserted within 2 granted cycles (starvation bound).
